// File: rtl/dot_acc_pkg.sv
// Shared types and constants for the dot-product accumulator slice.
`timescale 1ns/1ps
package dot_acc_pkg;

  // Default geometry: 5-bit dot-product samples summed eight at a time into 12 bits.
  localparam int unsigned IN_W_DEF  = 5;
  localparam int unsigned ACC_W_DEF = 12;
  localparam int unsigned LEN_DEF   = 8;

  // Largest value the upstream 2x2-bit dot-product cell can emit.
  localparam int unsigned DOT_MAX = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_adder.sv
// Combinational adder: accumulator plus zero-extended sample, with carry-out as overflow.
`timescale 1ns/1ps
module sat_adder
  import dot_acc_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [IN_W-1:0]  b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] full;

  // Form the sum one bit wider so the carry-out flags overflow.
  always_comb begin
    full = {1'b0, a} + {{(ACC_W + 1 - IN_W){1'b0}}, b};
    sum  = full[ACC_W-1:0];
    ovf  = full[ACC_W];
  end

endmodule

// File: rtl/dot_accumulator.sv
// Sums LEN consecutive dot-product samples into one saturating frame total and holds it
// on a valid/ready output until taken.
`timescale 1ns/1ps
module dot_accumulator
  import dot_acc_pkg::*;
#(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned LEN   = LEN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(LEN + 1);
  localparam logic [CntW-1:0] LenC = CntW'(LEN);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic             accept;
  logic [CntW-1:0]  cnt_inc;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;

  sat_adder #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_sat_adder (
    .a   (acc_q),
    .b   (in_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign accept  = in_valid & in_ready;
  assign cnt_inc = cnt_q + CntW'(1);

  // Next-state: frame FSM, sample counter and saturating accumulator.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;

    if (clear) begin
      // Abort wins over everything; a sample offered this cycle is dropped.
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = ACC_W'(in_data);
            cnt_d   = CntW'(1);
            sat_d   = 1'b0;
            state_d = (LEN == 1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            // Once saturated the carry keeps firing for any nonzero sample, so acc pins at max.
            acc_d = add_ovf ? {ACC_W{1'b1}} : add_sum;
            sat_d = sat_q | add_ovf;
            cnt_d = cnt_inc;
            if (cnt_inc == LenC) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Outputs come straight from registers or state decode; no input-to-output path.
  always_comb begin
    in_ready  = (state_q != DONE);
    out_valid = (state_q == DONE);
    out_data  = acc_q;
    out_sat   = sat_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed bench for dot_accumulator: a default 12-bit instance and a 6-bit instance
// driven by the same stimulus to reach saturation.
`timescale 1ns/1ps
module tb_dot_accumulator;
  import dot_acc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  in_data = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_sat, busy;
  logic [11:0] out_data;
  logic        s_in_ready, s_out_valid, s_out_sat, s_busy;
  logic [5:0]  s_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dot_accumulator #(
    .IN_W  (5),
    .ACC_W (12),
    .LEN   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  dot_accumulator #(
    .IN_W  (5),
    .ACC_W (6),
    .LEN   (8)
  ) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_data   (in_data),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_data  (s_out_data),
    .out_sat   (s_out_sat),
    .busy      (s_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and hold it until it is accepted (bounded).
  task automatic push(input logic [4:0] d);
    int i;
    in_valid = 1'b1;
    in_data  = d;
    i = 0;
    while (!in_ready && i < 20) begin
      step();
      i++;
    end
    if (!in_ready) check("push_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (!out_valid && i < 20) begin
      step();
      i++;
    end
    check(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check(tag, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset.
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 1. Reset mid-frame after three accepts.
    push(5'd1);
    push(5'd2);
    push(5'd3);
    check("t1_busy_pre", 32'(busy), 32'd1);
    check("t1_acc_pre", 32'(out_data), 32'd6);
    rst_n = 1'b0;
    #1;
    check("t1_busy_async", 32'(busy), 32'd0);
    step();
    step();
    check("t1_out_valid", 32'(out_valid), 32'd0);
    check("t1_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    step();
    check("t1_in_ready", 32'(in_ready), 32'd1);

    // 2. Back-to-back frame 1..8 -> 36.
    for (int i = 1; i <= 8; i++) begin
      push(5'(i));
      if (i == 7) check("t2_valid_early", 32'(out_valid), 32'd0);
    end
    check("t2_out_valid", 32'(out_valid), 32'd1);
    check("t2_out_data", 32'(out_data), 32'd36);
    check("t2_out_sat", 32'(out_sat), 32'd0);
    check("t2_in_ready", 32'(in_ready), 32'd0);

    // 3. Stall with in_valid high: total held, nothing accepted.
    in_valid = 1'b1;
    in_data  = 5'd5;
    repeat (5) step();
    check("t3_hold_data", 32'(out_data), 32'd36);
    check("t3_hold_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    handshake("t3_hs");
    check("t3_idle_busy", 32'(busy), 32'd0);
    check("t3_idle_data", 32'(out_data), 32'd0);
    for (int i = 0; i < 8; i++) push(5'd3);
    wait_done("t3_done");
    check("t3_out_data", 32'(out_data), 32'd24);
    handshake("t3_hs2");

    // 4. Eight 18s: 6-bit instance saturates on the 4th accept, 12-bit gives 144.
    push(5'(DOT_MAX));
    push(5'(DOT_MAX));
    push(5'(DOT_MAX));
    check("t4_acc3", 32'(s_out_data), 32'd54);
    check("t4_sat3", 32'(s_out_sat), 32'd0);
    push(5'(DOT_MAX));
    check("t4_acc4", 32'(s_out_data), 32'd63);
    check("t4_sat4", 32'(s_out_sat), 32'd1);
    for (int i = 0; i < 4; i++) push(5'(DOT_MAX));
    check("t4_s_valid", 32'(s_out_valid), 32'd1);
    check("t4_s_data", 32'(s_out_data), 32'd63);
    check("t4_s_sat", 32'(s_out_sat), 32'd1);
    check("t4_wide_data", 32'(out_data), 32'd144);
    check("t4_wide_sat", 32'(out_sat), 32'd0);
    handshake("t4_hs");
    for (int i = 0; i < 8; i++) push(5'd1);
    check("t4_s_valid2", 32'(s_out_valid), 32'd1);
    check("t4_s_data2", 32'(s_out_data), 32'd8);
    check("t4_s_sat2", 32'(s_out_sat), 32'd0);
    handshake("t4_hs2");

    // 5. Random bubbles on in_valid.
    for (int i = 1; i <= 8; i++) begin
      for (int b = 0; b < 4 && $urandom_range(1, 0) == 1; b++) step();
      push(5'(i));
      if (i == 7) check("t5_valid_early", 32'(out_valid), 32'd0);
    end
    wait_done("t5_done");
    check("t5_out_data", 32'(out_data), 32'd36);
    handshake("t5_hs");

    // 6. Clear mid-frame drops partial sum and the same-cycle sample.
    push(5'd4);
    push(5'd4);
    push(5'd4);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 5'd9;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("t6_clr_busy", 32'(busy), 32'd0);
    check("t6_clr_data", 32'(out_data), 32'd0);
    for (int i = 0; i < 8; i++) push(5'd2);
    check("t6_valid", 32'(out_valid), 32'd1);
    check("t6_out_data", 32'(out_data), 32'd16);
    // Clear in DONE beats out_ready.
    clear     = 1'b1;
    out_ready = 1'b1;
    step();
    clear     = 1'b0;
    out_ready = 1'b0;
    check("t6_done_clr_valid", 32'(out_valid), 32'd0);
    check("t6_done_clr_busy", 32'(busy), 32'd0);
    check("t6_done_clr_data", 32'(out_data), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
